// File: rtl/conv_requant_stage_pkg.sv
// Shared types and constants for the convolution requantisation stage.
package conv_requant_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int SAT_MAX_U = 255;
    localparam int SAT_MIN_S = -128;
    localparam int SAT_MAX_S = 127;

    localparam int unsigned SUM_W   = 34;
    localparam int unsigned BIAS_W  = 32;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 8;

endpackage

// File: rtl/conv_requant_stage_requant_pipe.sv
// Three-stage bias / rounding-shift / saturate datapath with a travelling valid bit.
module requant_pipe
    import conv_requant_stage_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_valid,
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    input  logic signed [BIAS_W-1:0]    i_bias,
    input  logic [SHIFT_W-1:0]          i_shift,
    input  logic                        i_relu,
    output logic                        o_valid,
    output logic [BYTE_W-1:0]           o_data,
    output logic                        o_pend
);

    localparam logic signed [SUM_W-1:0] W_ZERO  = '0;
    localparam logic signed [SUM_W-1:0] W_ONE   = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] W_MAX_U = SUM_W'(SAT_MAX_U);
    localparam logic signed [SUM_W-1:0] W_MIN_S = SUM_W'(SAT_MIN_S);
    localparam logic signed [SUM_W-1:0] W_MAX_S = SUM_W'(SAT_MAX_S);

    logic                    r_v1;
    logic                    r_v2;
    logic signed [SUM_W-1:0] r_sum;
    logic signed [SUM_W-1:0] r_shifted;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_round;
    logic signed [SUM_W-1:0] w_shifted;
    logic [BYTE_W-1:0]       w_sat;

    assign w_sum     = SUM_W'(i_acc) + SUM_W'(i_bias);
    assign w_round   = (i_shift == '0) ? W_ZERO : (W_ONE <<< (i_shift - SHIFT_W'(1)));
    assign w_shifted = (r_sum + w_round) >>> i_shift;
    assign o_pend    = r_v1 | r_v2;

    // Clamp the shifted value to the unsigned or signed byte range.
    always_comb begin
        w_sat = r_shifted[BYTE_W-1:0];
        if (i_relu) begin
            if (r_shifted < W_ZERO) begin
                w_sat = '0;
            end else if (r_shifted > W_MAX_U) begin
                w_sat = BYTE_W'(SAT_MAX_U);
            end
        end else begin
            if (r_shifted < W_MIN_S) begin
                w_sat = BYTE_W'(SAT_MIN_S);
            end else if (r_shifted > W_MAX_S) begin
                w_sat = BYTE_W'(SAT_MAX_S);
            end
        end
    end

    // Pipeline registers; data stages only load when their input is valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            o_valid   <= 1'b0;
            r_sum     <= '0;
            r_shifted <= '0;
            o_data    <= '0;
        end else begin
            r_v1    <= i_valid;
            r_v2    <= r_v1;
            o_valid <= r_v2;
            if (i_valid) begin
                r_sum <= w_sum;
            end
            if (r_v1) begin
                r_shifted <= w_shifted;
            end
            if (r_v2) begin
                o_data <= w_sat;
            end
        end
    end

endmodule

// File: rtl/conv_requant_stage.sv
// Requantises the conv accumulator stream to bytes for process_fifo, with
// pixel/row/layer counting and admission control on FIFO occupancy.
module conv_requant_stage
    import conv_requant_stage_pkg::*;
#(
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH   = 512,
    parameter int unsigned FIFO_MARGIN  = 8,
    parameter int unsigned DCOUNT_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        Start,
    input  logic [CNT_W-1:0]            no_of_output_layers,
    input  logic [CNT_W-1:0]            output_layer_row_size,
    input  logic [CNT_W-1:0]            output_layer_col_size,
    input  logic [SHIFT_W-1:0]          shift_amt,
    input  logic                        relu_en,
    input  logic signed [BIAS_W-1:0]    layer_bias,
    output logic [CNT_W-1:0]            layer_idx,
    input  logic signed [ACC_WIDTH-1:0] acc_data,
    input  logic                        acc_valid,
    output logic                        acc_ready,
    output logic [BYTE_W-1:0]           fifo_din,
    output logic                        fifo_wr_en,
    input  logic [DCOUNT_WIDTH-1:0]     fifo_dcount,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned CREDIT_W     = DCOUNT_WIDTH + 1;
    localparam int unsigned INFL_W       = 3;
    localparam int unsigned CREDIT_LIMIT = FIFO_DEPTH - FIFO_MARGIN;

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_layers;
    logic [CNT_W-1:0]    r_rows;
    logic [CNT_W-1:0]    r_cols;
    logic [SHIFT_W-1:0]  r_shift;
    logic                r_relu;
    logic [CNT_W-1:0]    r_col;
    logic [CNT_W-1:0]    r_row;
    logic [CNT_W-1:0]    r_layer;
    logic [INFL_W-1:0]   r_inflight;
    logic                r_wr_d1;

    logic [CREDIT_W-1:0] w_credit;
    logic                w_ready;
    logic                w_accept;
    logic                w_last_col;
    logic                w_last_row;
    logic                w_last_layer;
    logic                w_pipe_valid;
    logic [BYTE_W-1:0]   w_pipe_data;
    logic                w_pend;

    // Inflight covers beats in the pipe plus the one-cycle data_count lag.
    assign w_credit     = CREDIT_W'(fifo_dcount) + CREDIT_W'(r_inflight) + CREDIT_W'(1);
    assign w_ready      = (r_state == ST_RUN) && (w_credit <= CREDIT_W'(CREDIT_LIMIT));
    assign w_accept     = acc_valid && w_ready;
    assign w_last_col   = (r_col   == r_cols   - CNT_W'(1));
    assign w_last_row   = (r_row   == r_rows   - CNT_W'(1));
    assign w_last_layer = (r_layer == r_layers - CNT_W'(1));

    assign acc_ready  = w_ready;
    assign layer_idx  = r_layer;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fifo_wr_en = w_pipe_valid;
    assign fifo_din   = w_pipe_data;

    requant_pipe #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_accept),
        .i_acc   (acc_data),
        .i_bias  (layer_bias),
        .i_shift (r_shift),
        .i_relu  (r_relu),
        .o_valid (w_pipe_valid),
        .o_data  (w_pipe_data),
        .o_pend  (w_pend)
    );

    // Run-control FSM with config latch and col/row/layer counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_layers <= '0;
            r_rows   <= '0;
            r_cols   <= '0;
            r_shift  <= '0;
            r_relu   <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
            r_layer  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_layers <= no_of_output_layers;
                        r_rows   <= output_layer_row_size;
                        r_cols   <= output_layer_col_size;
                        r_shift  <= shift_amt;
                        r_relu   <= relu_en;
                        r_col    <= '0;
                        r_row    <= '0;
                        r_layer  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_last_col) begin
                            r_col <= '0;
                            if (w_last_row) begin
                                r_row <= '0;
                                if (w_last_layer) begin
                                    r_layer <= '0;
                                    r_state <= ST_DRAIN;
                                end else begin
                                    r_layer <= r_layer + CNT_W'(1);
                                end
                            end else begin
                                r_row <= r_row + CNT_W'(1);
                            end
                        end else begin
                            r_col <= r_col + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last write is on the output now when the early stages are empty.
                    if (!w_pend) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Inflight credit: +1 on accept, -1 the cycle after each FIFO write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= '0;
            r_wr_d1    <= 1'b0;
        end else begin
            r_wr_d1 <= w_pipe_valid;
            case ({w_accept, r_wr_d1})
                2'b10:   r_inflight <= r_inflight + INFL_W'(1);
                2'b01:   r_inflight <= r_inflight - INFL_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_requant_stage.sv
// Scoreboard bench for conv_requant_stage: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every FIFO write.
`timescale 1ns/1ps
module tb_conv_requant_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  no_of_output_layers = '0;
    logic [7:0]  output_layer_row_size = '0;
    logic [7:0]  output_layer_col_size = '0;
    logic [4:0]  shift_amt = '0;
    logic        relu_en = 1'b0;
    logic signed [31:0] layer_bias;
    logic [7:0]  layer_idx;
    logic signed [31:0] acc_data = '0;
    logic        acc_valid = 1'b0;
    logic        acc_ready;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic [9:0]  fifo_dcount = '0;
    logic        busy;
    logic        done;

    logic signed [31:0] bias_const = '0;
    bit          use_tab = 1'b0;
    bit          rnd_valid = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    int n_wr = 0;
    int n_done = 0;
    int cyc = 0;
    int first_acc_cyc = -1;
    int first_wr_cyc = -1;

    logic [7:0] exp_q[$];

    localparam int ACC1[6] = '{0, 24, -100, 4088, 16, 40};
    localparam int EXP1[6] = '{1, 2, 0, 255, 2, 3};

    conv_requant_stage dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .Start                 (Start),
        .no_of_output_layers   (no_of_output_layers),
        .output_layer_row_size (output_layer_row_size),
        .output_layer_col_size (output_layer_col_size),
        .shift_amt             (shift_amt),
        .relu_en               (relu_en),
        .layer_bias            (layer_bias),
        .layer_idx             (layer_idx),
        .acc_data              (acc_data),
        .acc_valid             (acc_valid),
        .acc_ready             (acc_ready),
        .fifo_din              (fifo_din),
        .fifo_wr_en            (fifo_wr_en),
        .fifo_dcount           (fifo_dcount),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic signed [31:0] tab_bias(input logic [7:0] idx);
        case (idx)
            8'd1:    return 32'sd100;
            8'd2:    return -32'sd100;
            default: return 32'sd0;
        endcase
    endfunction

    assign layer_bias = use_tab ? tab_bias(layer_idx) : bias_const;

    function automatic logic [7:0] ref_byte(input longint a, input longint b,
                                            input int sh, input bit relu);
        longint s;
        s = a + b;
        if (sh > 0) s = s + (longint'(1) <<< (sh - 1));
        s = s >>> sh;
        if (relu) begin
            if (s < 0)   return 8'd0;
            if (s > 255) return 8'd255;
        end else begin
            if (s < -128) return 8'h80;
            if (s > 127)  return 8'h7F;
        end
        return 8'(s);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard queue.
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            n_wr++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            if (fifo_dcount >= 10'd511) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wr_while_full: got dcount %0d, want < 511", fifo_dcount);
            end
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got byte %0d, want no write", fifo_din);
            end else begin
                check("out_byte", int'(fifo_din), int'(exp_q.pop_front()));
            end
        end
        if (done) n_done++;
    end

    task automatic start_run(input int l, input int r, input int c, input int sh, input bit relu);
        @(negedge clk);
        no_of_output_layers   = 8'(l);
        output_layer_row_size = 8'(r);
        output_layer_col_size = 8'(c);
        shift_amt             = 5'(sh);
        relu_en               = relu;
        Start                 = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check("busy_rise", int'(busy), 1);
    endtask

    task automatic send_beat(input int d);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 2000 && !got; t++) begin
            @(negedge clk);
            acc_valid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            acc_data  = 32'(d);
            #1;
            if (acc_valid && acc_ready) begin
                got = 1'b1;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: got no accept, want accept of %0d", d);
        end
    endtask

    task automatic finish_run(input string name, input int exp_wr, input int wr0, input int d0);
        int t;
        @(negedge clk);
        acc_valid = 1'b0;
        t = 0;
        while (busy && t < 50000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check({name, "_idle"}, int'(busy), 0);
        check({name, "_writes"}, n_wr - wr0, exp_wr);
        check({name, "_done"}, n_done - d0, 1);
        check({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic run_basic(input string tag);
        int wr0, d0;
        wr0 = n_wr; d0 = n_done;
        first_acc_cyc = -1; first_wr_cyc = -1;
        use_tab = 1'b0; bias_const = 32'sd8; rnd_valid = 1'b0;
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(EXP1[i]));
        start_run(1, 2, 3, 4, 1'b1);
        for (int i = 0; i < 6; i++) send_beat(ACC1[i]);
        finish_run(tag, 6, wr0, d0);
        check({tag, "_latency"}, first_wr_cyc - first_acc_cyc, 3);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0, d0, hi;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_acc_ready", int'(acc_ready), 0);
        check("rst_wr_en", int'(fifo_wr_en), 0);
        check("rst_din", int'(fifo_din), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_layer_idx", int'(layer_idx), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_not_ready", int'(acc_ready), 0);

        // Basic path
        run_basic("basic");

        // Signed clamp
        wr0 = n_wr; d0 = n_done;
        bias_const = 32'sd0;
        exp_q.push_back(8'h7F); exp_q.push_back(8'h80); exp_q.push_back(8'hFB);
        start_run(1, 1, 3, 0, 1'b0);
        send_beat(200); send_beat(-200); send_beat(-5);
        finish_run("signed", 3, wr0, d0);

        // Backpressure at the credit boundary
        wr0 = n_wr; d0 = n_done;
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        fifo_dcount = 10'd504;
        start_run(1, 1, 4, 0, 1'b1);
        acc_valid = 1'b1; acc_data = 32'sd1; hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (acc_ready) hi++;
        end
        check("bp_hold_ready_cycles", hi, 0);
        check("bp_hold_writes", n_wr - wr0, 0);
        @(negedge clk); fifo_dcount = 10'd503; #1;
        check("bp_edge_ready", int'(acc_ready), 1);
        @(negedge clk); acc_data = 32'sd2; #1;
        check("bp_edge_block", int'(acc_ready), 0);
        acc_valid = 1'b0;
        fifo_dcount = 10'd400;
        send_beat(2); send_beat(3); send_beat(4);
        finish_run("backpressure", 4, wr0, d0);
        fifo_dcount = 10'd0;

        // Layer bias switch
        wr0 = n_wr; d0 = n_done;
        use_tab = 1'b1;
        exp_q.push_back(8'd0);   exp_q.push_back(8'd0);
        exp_q.push_back(8'd100); exp_q.push_back(8'd100);
        exp_q.push_back(8'h9C);  exp_q.push_back(8'h9C);
        start_run(3, 1, 2, 0, 1'b0);
        for (int i = 0; i < 6; i++) send_beat(0);
        finish_run("layer_bias", 6, wr0, d0);
        check("layer_idx_end", int'(layer_idx), 0);
        use_tab = 1'b0;

        // Full frame with random valid and an ignored second Start
        wr0 = n_wr; d0 = n_done;
        bias_const = 32'sd3; rnd_valid = 1'b1;
        for (int i = 0; i < 15125; i++)
            exp_q.push_back(ref_byte(longint'((i % 1200) - 200), 64'sd3, 1, 1'b1));
        start_run(5, 55, 55, 1, 1'b1);
        for (int i = 0; i < 15125; i++) begin
            if (i == 100) begin
                no_of_output_layers = 8'd1; output_layer_row_size = 8'd1;
                output_layer_col_size = 8'd1; shift_amt = 5'd0; relu_en = 1'b0;
                Start = 1'b1;
            end
            send_beat((i % 1200) - 200);
            Start = 1'b0;
            if (i == 101) check("frame_busy_after_restart", int'(busy), 1);
        end
        finish_run("frame", 15125, wr0, d0);
        rnd_valid = 1'b0;

        // Mid-run reset
        bias_const = 32'sd0;
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i + 1));
        start_run(2, 1, 8, 0, 1'b1);
        for (int i = 0; i < 10; i++) send_beat(i + 1);
        @(negedge clk);
        check("pre_rst_layer_idx", int'(layer_idx), 1);
        #3;
        reset_n = 1'b0;
        acc_valid = 1'b0;
        #1;
        exp_q.delete();
        d0 = n_done;
        check("midrst_acc_ready", int'(acc_ready), 0);
        check("midrst_wr_en", int'(fifo_wr_en), 0);
        check("midrst_din", int'(fifo_din), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_layer_idx", int'(layer_idx), 0);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_done", n_done - d0, 0);
        run_basic("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
